adder_pipe: RTL and testbench



---
 rtl/adder_pipe_pkg.sv | 24 ++
 rtl/adder_slice.sv | 33 +++
 rtl/adder_pipe.sv | 121 ++++++++++++
 tb/tb_adder_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined adder: configuration helpers and the
// per-stage control record. The data fields of a stage (remaining operand
// chunks, partial sum, tag) have widths that depend on the instance
// parameters, so they live next to the flags in the top module.
package adder_pipe_pkg;

    // Control part of one pipeline stage record
    typedef struct packed {
        logic valid;  // stage holds a live beat
        logic carry;  // carry out of the chunk resolved in this stage
        logic cmsb;   // carry into the top bit of this stage's chunk
    } stage_flags_t;

    // Width of the carry-chain chunk resolved per stage
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // Legal configuration: 1..WIDTH stages, WIDTH an exact multiple of STAGES
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CW-bit adder with carry-in. Besides the sum and carry-out it
// exposes the carry into its own MSB so the top chunk can derive signed
// overflow as (carry into MSB) ^ (carry out).
module adder_slice #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    if (CW == 1) begin : g_single
        // One-bit chunk: the carry into the MSB is the incoming carry itself
        logic [1:0] total;
        assign total = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        assign sum   = total[0];
        assign cout  = total[1];
        assign cmsb  = cin;
    end else begin : g_multi
        // Low bits first so their carry (the carry into the MSB) is visible
        logic [CW-1:0] low;
        logic [1:0]    top;
        assign low  = {1'b0, a[CW-2:0]} + {1'b0, b[CW-2:0]} + {{(CW-1){1'b0}}, cin};
        assign cmsb = low[CW-1];
        assign top  = {1'b0, a[CW-1]} + {1'b0, b[CW-1]} + {1'b0, cmsb};
        assign sum  = {top[0], low[CW-2:0]};
        assign cout = top[1];
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder with carry-in. Each of STAGES register stages
// resolves one CW-bit chunk of the carry chain, LSB chunk first. A beat
// carries its not-yet-consumed operand bits and its growing partial sum down
// the pipe; the last stage drives the outputs. A single global advance enable
// moves every stage at once, so bubbles are kept rather than squeezed out.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW   = chunk_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // Stage registers; operands shift right by CW per stage so the next chunk
    // is always in the low bits, and the partial sum fills in from the top so
    // it is aligned once the last chunk has been added.
    stage_flags_t     flags_reg [STAGES];
    logic [WIDTH-1:0] rem_a_reg [STAGES];
    logic [WIDTH-1:0] rem_b_reg [STAGES];
    logic [WIDTH-1:0] psum_reg  [STAGES];
    logic [TAG_W-1:0] tag_reg   [STAGES];

    // Values entering each stage (from the input port or the previous stage)
    logic             valid_in  [STAGES];
    logic [WIDTH-1:0] rem_a_in  [STAGES];
    logic [WIDTH-1:0] rem_b_in  [STAGES];
    logic [WIDTH-1:0] psum_in   [STAGES];
    logic             carry_in  [STAGES];
    logic [TAG_W-1:0] tag_in    [STAGES];

    logic [CW-1:0]    slice_sum  [STAGES];
    logic             slice_cout [STAGES];
    logic             slice_cmsb [STAGES];

    logic adv;

    // The whole pipe moves unless a finished result is waiting on the consumer
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign valid_in[gi] = in_valid;
            assign rem_a_in[gi] = a;
            assign rem_b_in[gi] = b;
            assign psum_in[gi]  = '0;
            assign carry_in[gi] = cin;
            assign tag_in[gi]   = in_tag;
        end else begin : g_link
            assign valid_in[gi] = flags_reg[gi-1].valid;
            assign rem_a_in[gi] = rem_a_reg[gi-1];
            assign rem_b_in[gi] = rem_b_reg[gi-1];
            assign psum_in[gi]  = psum_reg[gi-1];
            assign carry_in[gi] = flags_reg[gi-1].carry;
            assign tag_in[gi]   = tag_reg[gi-1];
        end

        adder_slice #(
            .CW(CW)
        ) u_slice (
            .a    (rem_a_in[gi][CW-1:0]),
            .b    (rem_b_in[gi][CW-1:0]),
            .cin  (carry_in[gi]),
            .sum  (slice_sum[gi]),
            .cout (slice_cout[gi]),
            .cmsb (slice_cmsb[gi])
        );
    end

    // Advance all stages together; reset kills every beat and zeroes the output stage
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rst) begin
                flags_reg[k].valid <= 1'b0;
                if (k == LAST) begin
                    flags_reg[k].carry <= 1'b0;
                    flags_reg[k].cmsb  <= 1'b0;
                    psum_reg[k]        <= '0;
                    tag_reg[k]         <= '0;
                end
            end else if (adv) begin
                flags_reg[k].valid <= valid_in[k];
                flags_reg[k].carry <= slice_cout[k];
                flags_reg[k].cmsb  <= slice_cmsb[k];
                rem_a_reg[k]       <= rem_a_in[k] >> CW;
                rem_b_reg[k]       <= rem_b_in[k] >> CW;
                psum_reg[k]        <= (psum_in[k] >> CW) | (WIDTH'(slice_sum[k]) << (WIDTH - CW));
                tag_reg[k]         <= tag_in[k];
            end
        end
    end

    assign out_valid = flags_reg[LAST].valid;
    assign sum       = psum_reg[LAST];
    assign cout      = flags_reg[LAST].carry;
    assign ovf       = flags_reg[LAST].cmsb ^ flags_reg[LAST].carry;
    assign out_tag   = tag_reg[LAST];

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: a driver feeds queued beats and pushes the
// reference result on every accepted beat; a monitor pops and compares on
// every consumed result. Extra WIDTH=16 instances cover other depths.
module tb_adder_pipe;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .out_tag(out_tag)
    );

    // WIDTH=16 sweep instances sharing one stimulus
    logic        w_valid;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic        w_cin;
    logic [3:0]  w_tag;
    logic        w_ready;
    logic        w_in_ready  [3];
    logic        w_out_valid [3];
    logic [15:0] w_sum       [3];
    logic        w_cout      [3];
    logic        w_ovf       [3];
    logic [3:0]  w_out_tag   [3];

    function automatic int w16_stages(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_w16
        adder_pipe #(.WIDTH(16), .STAGES(w16_stages(gi)), .TAG_W(4)) u_w16 (
            .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_in_ready[gi]),
            .a(w_a), .b(w_b), .cin(w_cin), .in_tag(w_tag),
            .out_valid(w_out_valid[gi]), .out_ready(w_ready),
            .sum(w_sum[gi]), .cout(w_cout[gi]), .ovf(w_ovf[gi]), .out_tag(w_out_tag[gi])
        );
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [TAG_W-1:0] tag;
    } beat_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
    } exp_t;

    beat_t pend[$];
    exp_t  sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;
    int n_out = 0;
    int n_drop = 0;
    int run_len = 0;
    int max_run = 0;
    bit lat_check = 1'b1;
    bit gap_en = 1'b0;
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;
    logic             last_ovf;
    logic [TAG_W-1:0] last_tag;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer arithmetic on the unsigned and signed interpretations
    function automatic exp_t model(input beat_t bt, input int c);
        exp_t e;
        int   full;
        int   sa;
        int   sbv;
        int   ssum;
        full = int'(bt.a) + int'(bt.b) + int'(bt.cin);
        sa   = (int'(bt.a) >= 128) ? int'(bt.a) - 256 : int'(bt.a);
        sbv  = (int'(bt.b) >= 128) ? int'(bt.b) - 256 : int'(bt.b);
        ssum = sa + sbv + int'(bt.cin);
        e.sum     = WIDTH'(full % 256);
        e.cout    = (full > 255);
        e.ovf     = (ssum > 127) || (ssum < -128);
        e.tag     = bt.tag;
        e.acc_cyc = c;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [7:0] pa, input logic [7:0] pb, input logic pc, input logic [3:0] pt);
        beat_t bt;
        bt.a = pa; bt.b = pb; bt.cin = pc; bt.tag = pt;
        pend.push_back(bt);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pend.size() != 0 || sb.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (pend.size() != 0 || sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d outstanding=%0d required 0", name, pend.size(), sb.size());
        end
    endtask

    // Driver: present the queue head after each rising edge
    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; in_tag = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b1;
                a        = pend[0].a;
                b        = pend[0].b;
                cin      = pend[0].cin;
                in_tag   = pend[0].tag;
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Acceptance: record the expected result of every beat the DUT takes
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && in_valid && in_ready && pend.size() != 0) begin
                sb.push_back(model(pend[0], cyc));
                void'(pend.pop_front());
                n_acc++;
                $display("in  cyc=%0d a=%02h b=%02h cin=%0d tag=%0d", cyc, a, b, cin, in_tag);
            end
        end
    end

    // Monitor: compare every consumed result against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            run_len = out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (!rst && out_valid && out_ready) begin
                $display("out cyc=%0d sum=%02h cout=%0d ovf=%0d tag=%0d", cyc, sum, cout, ovf, out_tag);
                last_sum = sum; last_cout = cout; last_ovf = ovf; last_tag = out_tag;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got sum=0x%0h tag=%0d, required no output", sum, out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    if (lat_check) chk("latency", 32'(cyc - e.acc_cyc), 32'(STAGES));
                    n_out++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] snap_sum;
        logic [TAG_W-1:0] snap_tag;
        logic             snap_cout;
        logic             snap_ovf;
        int               n;
        int               base_out;
        int               c0;
        bit               seen [3];
        int               lat  [3];

        rst = 1'b1; out_ready = 1'b1;
        w_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_tag = '0; w_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed values
        push(8'h4A, 8'h53, 1'b0, 4'd3);
        drain("d1");
        chk("d1_sum", 32'(last_sum), 32'h9D);
        chk("d1_cout_ovf", 32'({last_cout, last_ovf}), 32'b01);
        chk("d1_tag", 32'(last_tag), 32'd3);
        push(8'hFF, 8'h00, 1'b1, 4'd5);
        drain("d2");
        chk("d2_sum", 32'(last_sum), 32'h00);
        chk("d2_cout_ovf", 32'({last_cout, last_ovf}), 32'b10);
        push(8'h80, 8'h80, 1'b0, 4'd6);
        drain("d3");
        chk("d3_sum", 32'(last_sum), 32'h00);
        chk("d3_cout_ovf", 32'({last_cout, last_ovf}), 32'b11);

        // Back-to-back stream of 16 beats, tags 0..15
        max_run = 0;
        base_out = n_out;
        for (int i = 0; i < 16; i++)
            push(8'($urandom), 8'($urandom), 1'($urandom), 4'(i));
        drain("stream");
        chk("stream_run", 32'(max_run), 32'd16);
        chk("stream_count", 32'(n_out - base_out), 32'd16);

        // Random input gaps and random consumer backpressure
        lat_check = 1'b0;
        gap_en = 1'b1;
        for (int i = 0; i < 40; i++)
            push(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
        n = 0;
        while ((pend.size() != 0 || sb.size() != 0) && n < 600) begin
            @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain("random");
        gap_en = 1'b0;

        // Stall with a full pipe
        for (int i = 0; i < 8; i++)
            push(8'($urandom), 8'($urandom), 1'($urandom), 4'(i + 8));
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        snap_sum = sum; snap_cout = cout; snap_ovf = ovf; snap_tag = out_tag;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'(snap_sum));
            chk("stall_flags", 32'({cout, ovf, out_tag}), 32'({snap_cout, snap_ovf, snap_tag}));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain("stall");
        chk("acc_vs_out", 32'(n_acc), 32'(n_out + n_drop));

        // Reset with two beats in flight
        @(posedge clk); #1 out_ready = 1'b0;
        push(8'h11, 8'h22, 1'b0, 4'd1);
        push(8'h33, 8'h44, 1'b1, 4'd2);
        n = 0;
        while (pend.size() != 0 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 rst = 1'b1;
        n_drop += sb.size();
        sb.delete();
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sum_tag", 32'({sum, out_tag}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("dropped", 32'(n_drop), 32'd2);

        // WIDTH=16 sweep over depths 1, 4, 16
        @(posedge clk); #1 w_valid = 1'b1; w_a = 16'hFFFF; w_b = 16'h0001; w_tag = 4'd9;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            seen[i] = 1'b0; lat[i] = -1;
            chk("w16_in_ready", 32'(w_in_ready[i]), 32'd1);
        end
        @(posedge clk); #1 w_valid = 1'b0;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (w_out_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    lat[i] = cyc - c0;
                    $display("w16 stages=%0d cyc=%0d sum=%04h cout=%0d ovf=%0d tag=%0d",
                             w16_stages(i), cyc, w_sum[i], w_cout[i], w_ovf[i], w_out_tag[i]);
                    chk("w16_sum", 32'(w_sum[i]), 32'd0);
                    chk("w16_cout_ovf", 32'({w_cout[i], w_ovf[i]}), 32'b10);
                    chk("w16_tag", 32'(w_out_tag[i]), 32'd9);
                end
            end
        end
        for (int i = 0; i < 3; i++)
            chk("w16_latency", 32'(lat[i]), 32'(w16_stages(i)));

        // Configuration legality helper
        chk("cfg_illegal_8_3", 32'(adder_pipe_pkg::cfg_ok(8, 3)), 32'd0);
        chk("cfg_legal_16_4", 32'(adder_pipe_pkg::cfg_ok(16, 4)), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
